// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: owner states, port indices
// and the burst-limit helper used by both the arbiter and its pointer block.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Highest burst count value; the counter saturates here.
    function automatic logic [3:0] burst_limit(input int max_burst);
        return 4'(max_burst - 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_pointer.sv
// Round-robin pointer (last port served) and per-owner burst counter.
module rr_pointer
    import ram_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       gnt_any,
    input  logic       gnt_port,
    input  logic       same_owner,
    output logic       ptr,
    output logic [3:0] burst_cnt
);

    localparam logic [3:0] CNT_LIMIT = burst_limit(MAX_BURST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= PORT_B;
            burst_cnt <= '0;
        end else if (ce) begin
            if (gnt_any) ptr <= gnt_port;
            // Any edge that does not extend the current owner's run restarts it.
            if (gnt_any && same_owner) begin
                if (burst_cnt < CNT_LIMIT) burst_cnt <= burst_cnt + 4'd1;
            end else begin
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port single-RAM arbiter: loader (A) and CPU (B) share one synchronous RAM
// with burst-limited round-robin ownership and a boot-time A-only mode.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              boot,
    input  logic              a_req,
    input  logic              a_rw,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_rw,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_enable,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    localparam logic [3:0] CNT_LIMIT = burst_limit(MAX_BURST);

    state_t          state, state_nxt;
    logic            pick, pick_port, gnt_any, gnt_port, same_owner;
    logic            a_elig, b_elig, at_limit, ptr, en;
    logic [3:0]      burst_cnt;
    logic [1:0][1:0] rv_pipe;   // [stage][port]
    logic            sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign a_elig   = a_req;
    assign b_elig   = b_req & ~boot;
    assign at_limit = (burst_cnt >= CNT_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    state <= IDLE;
        else if (ce) state <= state_nxt;
    end

    always_comb begin
        pick      = 1'b0;
        pick_port = PORT_A;
        case (state)
            OWN_A: begin
                if (a_elig) begin
                    pick      = 1'b1;
                    pick_port = (b_elig && at_limit) ? PORT_B : PORT_A;
                end else if (b_elig) begin
                    pick      = 1'b1;
                    pick_port = PORT_B;
                end
            end
            OWN_B: begin
                // boot masks b_elig, so B ownership lapses here during boot.
                if (b_elig) begin
                    pick      = 1'b1;
                    pick_port = (a_elig && at_limit) ? PORT_A : PORT_B;
                end else if (a_elig) begin
                    pick      = 1'b1;
                    pick_port = PORT_A;
                end
            end
            default: begin
                if (a_elig && b_elig) begin
                    pick      = 1'b1;
                    pick_port = ~ptr;
                end else if (a_elig || b_elig) begin
                    pick      = 1'b1;
                    pick_port = a_elig ? PORT_A : PORT_B;
                end
            end
        endcase
        gnt_any    = pick & ce;
        gnt_port   = pick_port;
        same_owner = (state == OWN_A && pick_port == PORT_A) ||
                     (state == OWN_B && pick_port == PORT_B);
        state_nxt  = IDLE;
        if (gnt_any) state_nxt = (pick_port == PORT_A) ? OWN_A : OWN_B;
    end

    rr_pointer #(.MAX_BURST(MAX_BURST)) u_rr (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .gnt_any    (gnt_any),
        .gnt_port   (gnt_port),
        .same_owner (same_owner),
        .ptr        (ptr),
        .burst_cnt  (burst_cnt)
    );

    assign sel_rw    = (gnt_port == PORT_A) ? a_rw    : b_rw;
    assign sel_addr  = (gnt_port == PORT_A) ? a_addr  : b_addr;
    assign sel_wdata = (gnt_port == PORT_A) ? a_wdata : b_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en       <= 1'b0;
            ram_rw   <= 1'b0;
            ram_addr <= '0;
            ram_in   <= '0;
            rv_pipe  <= '0;
        end else if (ce) begin
            en                 <= gnt_any;
            rv_pipe[0][PORT_A] <= gnt_any & (gnt_port == PORT_A) & ~sel_rw;
            rv_pipe[0][PORT_B] <= gnt_any & (gnt_port == PORT_B) & ~sel_rw;
            rv_pipe[1]         <= rv_pipe[0];
            if (gnt_any) begin
                ram_rw   <= sel_rw;
                ram_addr <= sel_addr;
                ram_in   <= sel_wdata;
            end
        end
    end

    assign ram_enable = en & ce;
    assign a_gnt      = gnt_any & (gnt_port == PORT_A) & rst;
    assign b_gnt      = gnt_any & (gnt_port == PORT_B) & rst;
    assign a_rvalid   = rv_pipe[1][PORT_A] & ce;
    assign b_rvalid   = rv_pipe[1][PORT_B] & ce;
    assign a_rdata    = a_rvalid ? ram_out : '0;
    assign b_rdata    = b_rvalid ? ram_out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM + ownership model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_arbiter;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst, ce, boot;
    logic              a_req, a_rw, b_req, b_rw;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              ram_enable, ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_in;
    logic [DATA_W-1:0] ram_out = '0;

    int n_chk = 0;
    int n_fail = 0;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .ce(ce), .boot(boot),
        .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_in(ram_in), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        logic [DATA_W-1:0] v;
        v = DATA_W'(i * 16'h9E37) ^ 16'h5A5A;
        if (i == 5) v = 16'h1234;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM: read data appears the cycle after the enable.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (ram_enable) begin
                if (ram_rw) ram[ram_addr] <= ram_in;
                else        ram_out <= ram[ram_addr];
            end
        end
    end

    // Reference model, kept in "ce-cycle" time: run = consecutive grants to owner.
    int                owner, run, last, kce;
    bit                pend_en, pend_rw;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic [DATA_W-1:0] smem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rv_data [int];
    int                rv_port [int];

    function automatic int winner();
        bit ea, eb;
        ea = a_req;
        eb = b_req && !boot;
        if (!ce) return -1;
        if (owner == 0 && ea) return (eb && run >= MAX_BURST) ? 1 : 0;
        if (owner == 1 && eb) return (ea && run >= MAX_BURST) ? 0 : 1;
        if (ea && eb) return (last == 0) ? 1 : 0;
        if (ea) return 0;
        if (eb) return 1;
        return -1;
    endfunction

    initial begin
        int  w;
        bit  exp_a, exp_b;
        for (int i = 0; i < (1<<ADDR_W); i++) smem[i] = init_word(i);
        owner = -1; run = 0; last = 1; kce = 0; pend_en = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("reset_outputs", {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_enable, ram_rw,
                                      ram_addr, ram_in, a_rdata, b_rdata}, '0);
                owner = -1; run = 0; last = 1; pend_en = 0;
                rv_data.delete(); rv_port.delete();
            end else begin
                w = winner();
                chk("a_gnt", a_gnt, w == 0);
                chk("b_gnt", b_gnt, w == 1);
                chk("ram_enable", ram_enable, ce && pend_en);
                if (ce && pend_en) begin
                    chk("ram_rw", ram_rw, pend_rw);
                    chk("ram_addr", ram_addr, pend_addr);
                    chk("ram_in", ram_in, pend_data);
                end
                exp_a = ce && rv_port.exists(kce) && rv_port[kce] == 0;
                exp_b = ce && rv_port.exists(kce) && rv_port[kce] == 1;
                chk("a_rvalid", a_rvalid, exp_a);
                chk("b_rvalid", b_rvalid, exp_b);
                if (exp_a) chk("a_rdata", a_rdata, rv_data[kce]);
                if (exp_b) chk("b_rdata", b_rdata, rv_data[kce]);
                if (ce) begin
                    if (rv_port.exists(kce)) begin
                        rv_port.delete(kce);
                        rv_data.delete(kce);
                    end
                    if (w >= 0) begin
                        run       = (w == owner) ? run + 1 : 1;
                        owner     = w;
                        last      = w;
                        pend_en   = 1;
                        pend_rw   = (w == 0) ? a_rw : b_rw;
                        pend_addr = (w == 0) ? a_addr : b_addr;
                        pend_data = (w == 0) ? a_wdata : b_wdata;
                        if (pend_rw) smem[pend_addr] = pend_data;
                        else begin
                            rv_data[kce+2] = smem[pend_addr];
                            rv_port[kce+2] = w;
                        end
                    end else begin
                        owner = -1; run = 0; pend_en = 0;
                    end
                    kce++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [11:0] pat;
        int          idx, pulses, off_gnt, ga_cnt, gb_cnt, waited, rv_cnt;
        bit          got, ga, gb;
        logic [DATA_W-1:0] got_data;

        rst = 1'b0; ce = 1'b1; boot = 1'b0;
        a_req = 0; a_rw = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_rw = 0; b_addr = '0; b_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Read of RAM[5] by A: grant, then RAM strobe, then data.
        a_req = 1; a_rw = 0; a_addr = 8'h05;
        @(negedge clk); chk("rd_gnt", a_gnt, 1);
        step(); a_req = 0;
        @(negedge clk); chk("rd_strobe", {ram_enable, ram_addr}, {1'b1, 8'h05});
        step();
        @(negedge clk); chk("rd_return", {a_rvalid, a_rdata}, {1'b1, 16'h1234});
        step();

        // Continuous contention: bursts of MAX_BURST alternate.
        do_reset();
        a_req = 1; a_rw = 0; a_addr = 8'h01; b_req = 1; b_rw = 0; b_addr = 8'h02;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); pat[11-c] = a_gnt;
            step();
        end
        chk("burst_pattern", pat, 12'b1111_0000_1111);

        // Boot: A exclusive, then B admitted promptly.
        boot = 1; ga_cnt = 0; gb_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); ga_cnt += a_gnt; gb_cnt += b_gnt;
            step();
        end
        chk("boot_a_grants", ga_cnt, 20);
        chk("boot_b_grants", gb_cnt, 0);
        boot = 0; waited = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); if (b_gnt && waited < 0) waited = c;
            step();
        end
        chk("boot_release", (waited >= 0 && waited < MAX_BURST), 1);
        a_req = 0; b_req = 0;
        repeat (3) step();

        // Half-rate ce while B writes a block.
        do_reset();
        idx = 0; pulses = 0; off_gnt = 0;
        for (int c = 0; c < 20; c++) begin
            ce = (c % 2 == 0);
            b_req = (idx < 4); b_rw = 1; b_addr = 8'h10 + 8'(idx); b_wdata = 16'hBEEF;
            @(negedge clk);
            if (b_gnt) idx++;
            if (ram_enable) pulses++;
            if (!ce && (a_gnt || b_gnt)) off_gnt++;
            step();
        end
        ce = 1; b_req = 0;
        chk("ce_pulses", pulses, 4);
        chk("ce_off_grants", off_gnt, 0);
        for (int i = 0; i < 4; i++) chk("ce_write", ram[8'h10 + i], 16'hBEEF);

        // Reset right after a granted read: return is discarded.
        do_reset();
        a_req = 1; a_rw = 0; a_addr = 8'h07;
        @(negedge clk); chk("rst_rd_gnt", a_gnt, 1);
        step(); a_req = 0; rst = 0;
        step(); rst = 1; rv_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); rv_cnt += a_rvalid + b_rvalid;
            step();
        end
        chk("rst_no_rvalid", rv_cnt, 0);
        a_req = 1; b_req = 1; b_rw = 0;
        @(negedge clk); chk("rst_ptr_b", {a_gnt, b_gnt}, 2'b10);
        step(); a_req = 0; b_req = 0;
        repeat (4) step();

        // A writes, B reads the same word on the next cycle.
        do_reset();
        a_req = 1; a_rw = 1; a_addr = 8'h20; a_wdata = 16'h00AA;
        @(negedge clk); chk("wr_gnt", a_gnt, 1);
        step(); a_req = 0; b_req = 1; b_rw = 0; b_addr = 8'h20;
        @(negedge clk); chk("rd_after_wr_gnt", b_gnt, 1);
        step(); b_req = 0; got = 0; got_data = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (b_rvalid && !got) begin got = 1; got_data = b_rdata; end
            step();
        end
        chk("rd_after_wr", {got, got_data}, {1'b1, 16'h00AA});

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (!a_req && $urandom_range(0, 3) != 0) begin
                a_req = 1; a_rw = 1'($urandom); a_addr = 8'($urandom_range(0, 15));
                a_wdata = 16'($urandom);
            end
            if (!b_req && $urandom_range(0, 3) != 0) begin
                b_req = 1; b_rw = 1'($urandom); b_addr = 8'($urandom_range(0, 15));
                b_wdata = 16'($urandom);
            end
            ce   = ($urandom_range(0, 7) != 0);
            boot = ((c % 500) < 60);
            @(negedge clk); ga = a_gnt; gb = b_gnt;
            step();
            if (ga) a_req = 0;
            if (gb) b_req = 0;
        end
        a_req = 0; b_req = 0; ce = 1; boot = 0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
